// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM states, opcode/funct constants, ALU codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd, StMemWr,
        StWbR, StWbI, StWbMem, StBranch, StJump, StHalt
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;

    // Ctrl_alu codes
    localparam logic [4:0] AluAdd = 5'd0;
    localparam logic [4:0] AluSub = 5'd1;
    localparam logic [4:0] AluAnd = 5'd2;
    localparam logic [4:0] AluOr  = 5'd3;
    localparam logic [4:0] AluXor = 5'd4;
    localparam logic [4:0] AluNor = 5'd5;
    localparam logic [4:0] AluSlt = 5'd6;
    localparam logic [4:0] AluSll = 5'd7;
    localparam logic [4:0] AluSrl = 5'd8;
    localparam logic [4:0] AluSra = 5'd9;
    localparam logic [4:0] AluLui = 5'd10;

    // Mux select encodings
    localparam logic [1:0] RegDstRt    = 2'd0;
    localparam logic [1:0] RegDstRd    = 2'd1;
    localparam logic [1:0] RegDstR31   = 2'd2;
    localparam logic [1:0] SrcARegA    = 2'd0;
    localparam logic [1:0] SrcAPc      = 2'd1;
    localparam logic [1:0] SrcARegB    = 2'd2;
    localparam logic [1:0] SrcBRegB    = 2'd0;
    localparam logic [1:0] SrcBShamt   = 2'd1;
    localparam logic [1:0] SrcBImm     = 2'd2;
    localparam logic [1:0] SrcBFour    = 2'd3;
    localparam logic [1:0] M2RAlu      = 2'd0;
    localparam logic [1:0] M2RMem      = 2'd1;
    localparam logic [1:0] M2RPc       = 2'd2;
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcReg    = 2'd3;

    // R-type funct codes that go through EXEC_R/WB_R
    function automatic logic is_r_alu(logic [5:0] funct);
        case (funct)
            FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor, FnSlt,
            FnSll, FnSrl, FnSra: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(logic [5:0] funct);
        return (funct == FnSll) || (funct == FnSrl) || (funct == FnSra);
    endfunction

    function automatic logic is_i_alu(logic [5:0] op);
        case (op)
            OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpXori, OpLui: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface multi_cycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd;
    logic       Ctrl_MemWr;
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] pc_src;
    logic [1:0] Ctrl_regDst;
    logic [1:0] Ctrl_aluSrcA;
    logic [1:0] Ctrl_aluSrcB;
    logic [1:0] Ctrl_Mem2Reg;
    logic [4:0] Ctrl_alu;
    logic       Ctrl_ext;
    logic       Ctrl_regWr;
    logic       illegal;
    logic       halted;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_rd, Ctrl_MemWr, pc_wr, ir_wr, pc_src, Ctrl_regDst, Ctrl_aluSrcA,
               Ctrl_aluSrcB, Ctrl_Mem2Reg, Ctrl_alu, Ctrl_ext, Ctrl_regWr, illegal, halted
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_rd, Ctrl_MemWr, pc_wr, ir_wr, pc_src, Ctrl_regDst, Ctrl_aluSrcA,
               Ctrl_aluSrcB, Ctrl_Mem2Reg, Ctrl_alu, Ctrl_ext, Ctrl_regWr, illegal, halted
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational op/funct -> ALU operation and immediate extender mode.
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [4:0] alu_o,
    output logic       ext_o
);

    // R-type uses funct, I-type uses op; logical immediates zero-extend
    always_comb begin
        alu_o = AluAdd;
        ext_o = 1'b1;
        if (op_i == OpRtype) begin
            case (funct_i)
                FnSub, FnSubu: alu_o = AluSub;
                FnAnd:         alu_o = AluAnd;
                FnOr:          alu_o = AluOr;
                FnXor:         alu_o = AluXor;
                FnNor:         alu_o = AluNor;
                FnSlt:         alu_o = AluSlt;
                FnSll:         alu_o = AluSll;
                FnSrl:         alu_o = AluSrl;
                FnSra:         alu_o = AluSra;
                default:       ;
            endcase
        end else begin
            case (op_i)
                OpSlti:  alu_o = AluSlt;
                OpAndi:  begin alu_o = AluAnd; ext_o = 1'b0; end
                OpOri:   begin alu_o = AluOr;  ext_o = 1'b0; end
                OpXori:  begin alu_o = AluXor; ext_o = 1'b0; end
                OpLui:   alu_o = AluLui;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multicycle MIPS sequencer: Moore FSM driving datapath selects and strobes,
// stalling FETCH/MEM_RD/MEM_WR on mem_ready.
// Optional: define MC_CTRL_ILLEGAL_TRAP_EN to halt on an illegal instruction
// (otherwise illegal instructions execute as NOPs).
module multi_cycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    multi_cycle_ctrl_if.master     bus
);

    state_e     state_q, state_d;
    logic [4:0] dec_alu;
    logic       dec_ext;

    alu_op_decode u_alu_op_decode (
        .op_i    (bus.op),
        .funct_i (bus.funct),
        .alu_o   (dec_alu),
        .ext_o   (dec_ext)
    );

    // State register, asynchronously forced to FETCH by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StFetch;
        else      state_q <= state_d;
    end

    // Next-state and outputs; while rst is low every output holds its default
    always_comb begin
        state_d          = state_q;
        bus.mem_rd       = 1'b0;
        bus.Ctrl_MemWr   = 1'b0;
        bus.pc_wr        = 1'b0;
        bus.ir_wr        = 1'b0;
        bus.pc_src       = PcSrcAlu;
        bus.Ctrl_regDst  = RegDstRt;
        bus.Ctrl_aluSrcA = SrcARegA;
        bus.Ctrl_aluSrcB = SrcBRegB;
        bus.Ctrl_Mem2Reg = M2RAlu;
        bus.Ctrl_alu     = AluAdd;
        bus.Ctrl_ext     = 1'b1;
        bus.Ctrl_regWr   = 1'b0;
        bus.illegal      = 1'b0;
        bus.halted       = 1'b0;
        if (rst) begin
            case (state_q)
                StFetch: begin
                    bus.mem_rd       = 1'b1;
                    bus.Ctrl_aluSrcA = SrcAPc;
                    bus.Ctrl_aluSrcB = SrcBFour;
                    bus.pc_wr        = bus.mem_ready;
                    bus.ir_wr        = bus.mem_ready;
                    if (bus.mem_ready) state_d = StDecode;
                end
                StDecode: begin
                    if (bus.op == OpRtype && is_r_alu(bus.funct))   state_d = StExecR;
                    else if (bus.op == OpRtype && bus.funct == FnJr) state_d = StJump;
                    else if (is_i_alu(bus.op))                       state_d = StExecI;
                    else if (bus.op == OpLw || bus.op == OpSw)       state_d = StMemAddr;
                    else if (bus.op == OpBeq || bus.op == OpBne)     state_d = StBranch;
                    else if (bus.op == OpJ || bus.op == OpJal)       state_d = StJump;
                    else begin
                        bus.illegal = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_d = StHalt;
`else
                        state_d = StFetch;
`endif
                    end
                end
                StExecR, StWbR: begin
                    bus.Ctrl_alu = dec_alu;
                    if (is_shift(bus.funct)) begin
                        bus.Ctrl_aluSrcA = SrcARegB;
                        bus.Ctrl_aluSrcB = SrcBShamt;
                    end
                    if (state_q == StWbR) begin
                        bus.Ctrl_regDst = RegDstRd;
                        bus.Ctrl_regWr  = 1'b1;
                        state_d         = StFetch;
                    end else begin
                        state_d = StWbR;
                    end
                end
                StExecI, StWbI: begin
                    bus.Ctrl_aluSrcB = SrcBImm;
                    bus.Ctrl_alu     = dec_alu;
                    bus.Ctrl_ext     = dec_ext;
                    if (state_q == StWbI) begin
                        bus.Ctrl_regWr = 1'b1;
                        state_d        = StFetch;
                    end else begin
                        state_d = StWbI;
                    end
                end
                StMemAddr, StMemRd, StMemWr: begin
                    bus.Ctrl_aluSrcB = SrcBImm;
                    if (state_q == StMemAddr) begin
                        state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
                    end else if (state_q == StMemRd) begin
                        bus.mem_rd = 1'b1;
                        if (bus.mem_ready) state_d = StWbMem;
                    end else begin
                        bus.Ctrl_MemWr = 1'b1;
                        if (bus.mem_ready) state_d = StFetch;
                    end
                end
                StWbMem: begin
                    bus.Ctrl_Mem2Reg = M2RMem;
                    bus.Ctrl_regWr   = 1'b1;
                    state_d          = StFetch;
                end
                StBranch: begin
                    bus.Ctrl_alu = AluSub;
                    bus.pc_src   = PcSrcBranch;
                    bus.pc_wr    = (bus.op == OpBeq) ? bus.zero : ~bus.zero;
                    state_d      = StFetch;
                end
                StJump: begin
                    bus.pc_wr = 1'b1;
                    if (bus.op == OpJ) begin
                        bus.pc_src = PcSrcJump;
                    end else if (bus.op == OpJal) begin
                        bus.pc_src       = PcSrcJump;
                        bus.Ctrl_regDst  = RegDstR31;
                        bus.Ctrl_Mem2Reg = M2RPc;
                        bus.Ctrl_regWr   = 1'b1;
                    end else begin
                        bus.pc_src = PcSrcReg;
                    end
                    state_d = StFetch;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                StHalt: begin
                    bus.halted = 1'b1;
                    state_d    = StHalt;
                end
`endif
                default: state_d = StFetch;
            endcase
        end
    end

endmodule
